// File: rtl/sp_ram_ctrl.sv
// Request/response front-end for a single-port RAM with a shared bidirectional data bus.
// Sequences single-cycle writes, two-cycle reads and a bulk clear. Read data goes back
// over a valid/ready response channel. Only one access is in flight at a time.
module sp_ram_ctrl #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_SIZE  = 4,
    parameter int                    DEPTH      = 16,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_SIZE-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    input  logic                  clr_start,
    output logic                  clr_done,
    output logic                  busy,
    output logic                  ram_cs,
    output logic                  ram_wr,
    output logic                  ram_oe,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ADDR,
        RD_DATA,
        RESP,
        CLR
    } state_t;

    // One bit wider than the address so DEPTH == 2**ADDR_SIZE still compares correctly.
    localparam logic [ADDR_SIZE:0]   DEPTH_W  = (ADDR_SIZE + 1)'(DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [ADDR_SIZE-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    err_d, valid_d, done_d;
    logic                    cs_d, wr_d, oe_d;
    logic [ADDR_SIZE-1:0]    addr_d;
    logic                    in_range;

    assign req_ready = (state_q == IDLE) && !rst && !clr_start;
    assign busy      = (state_q != IDLE);
    assign in_range  = ({1'b0, req_addr} < DEPTH_W);

    // The bus is driven only while writing; during reads the RAM owns it.
    assign ram_data  = ram_wr ? dout_q : {DATA_WIDTH{1'bz}};

    // Next-state logic; also computes next-cycle values of every registered output.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rdata_d = resp_rdata;
        err_d   = resp_err;
        valid_d = resp_valid;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        wr_d    = 1'b0;
        oe_d    = 1'b0;
        addr_d  = ram_addr;

        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d = CLR;
                    cnt_d   = '0;
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = '0;
                    dout_d  = CLR_VALUE;
                end else if (req_valid && req_ready) begin
                    if (!in_range) begin
                        // Out-of-range writes vanish; reads answer with an error response.
                        if (!req_wr) begin
                            state_d = RESP;
                            valid_d = 1'b1;
                            err_d   = 1'b1;
                            rdata_d = '0;
                        end
                    end else if (req_wr) begin
                        state_d = WR;
                        cs_d    = 1'b1;
                        wr_d    = 1'b1;
                        addr_d  = req_addr;
                        dout_d  = req_wdata;
                    end else begin
                        state_d = RD_ADDR;
                        cs_d    = 1'b1;
                        addr_d  = req_addr;
                    end
                end
            end
            WR: begin
                state_d = IDLE;
            end
            RD_ADDR: begin
                state_d = RD_DATA;
                cs_d    = 1'b1;
                oe_d    = 1'b1;
            end
            RD_DATA: begin
                state_d = RESP;
                rdata_d = ram_data;
                err_d   = 1'b0;
                valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            CLR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    cs_d   = 1'b1;
                    wr_d   = 1'b1;
                    addr_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset abandons any access.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dout_q     <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            resp_valid <= 1'b0;
            clr_done   <= 1'b0;
            ram_cs     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_oe     <= 1'b0;
            ram_addr   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            resp_rdata <= rdata_d;
            resp_err   <= err_d;
            resp_valid <= valid_d;
            clr_done   <= done_d;
            ram_cs     <= cs_d;
            ram_wr     <= wr_d;
            ram_oe     <= oe_d;
            ram_addr   <= addr_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Directed self-checking bench for sp_ram_ctrl. Instance "a" uses DEPTH = 16,
// instance "b" uses DEPTH = 12 for the out-of-range cases. Each has its own RAM model.
module tb_sp_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- instance a (DEPTH = 16) ----------------
    logic       rst, req_valid, req_wr, resp_ready, clr_start;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       req_ready, resp_valid, resp_err, clr_done, busy;
    logic       ram_cs, ram_wr, ram_oe;
    logic [3:0] ram_addr;
    logic [7:0] resp_rdata;
    wire  [7:0] ram_data;

    sp_ram_ctrl #(.DATA_WIDTH(8), .ADDR_SIZE(4), .DEPTH(16), .CLR_VALUE(8'h00)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .clr_start(clr_start), .clr_done(clr_done), .busy(busy),
        .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_oe(ram_oe),
        .ram_addr(ram_addr), .ram_data(ram_data)
    );

    logic [7:0] mem_a [16];
    logic [7:0] rd_q_a;
    always @(posedge clk) begin
        if (ram_cs && ram_wr) mem_a[ram_addr] <= ram_data;
        else if (ram_cs)      rd_q_a          <= mem_a[ram_addr];
    end
    assign ram_data = (ram_cs && ram_oe && !ram_wr) ? rd_q_a : 8'bz;

    // ---------------- instance b (DEPTH = 12) ----------------
    logic       rst_b, req_valid_b, req_wr_b, resp_ready_b, clr_start_b;
    logic [3:0] req_addr_b;
    logic [7:0] req_wdata_b;
    logic       req_ready_b, resp_valid_b, resp_err_b, clr_done_b, busy_b;
    logic       ram_cs_b, ram_wr_b, ram_oe_b;
    logic [3:0] ram_addr_b;
    logic [7:0] resp_rdata_b;
    wire  [7:0] ram_data_b;

    sp_ram_ctrl #(.DATA_WIDTH(8), .ADDR_SIZE(4), .DEPTH(12), .CLR_VALUE(8'h00)) dut_b (
        .clk(clk), .rst(rst_b),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_wr(req_wr_b),
        .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b),
        .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
        .clr_start(clr_start_b), .clr_done(clr_done_b), .busy(busy_b),
        .ram_cs(ram_cs_b), .ram_wr(ram_wr_b), .ram_oe(ram_oe_b),
        .ram_addr(ram_addr_b), .ram_data(ram_data_b)
    );

    logic [7:0] mem_b [16];
    logic [7:0] rd_q_b;
    always @(posedge clk) begin
        if (ram_cs_b && ram_wr_b) mem_b[ram_addr_b] <= ram_data_b;
        else if (ram_cs_b)        rd_q_b            <= mem_b[ram_addr_b];
    end
    assign ram_data_b = (ram_cs_b && ram_oe_b && !ram_wr_b) ? rd_q_b : 8'bz;

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request on instance a and returns just after its accept edge.
    task automatic issue(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int guard;
        guard = 0;
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        while (!req_ready && guard < 50) begin
            tick();
            guard++;
        end
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL issue_ready: req_ready=%b required 1 (addr %0d)", req_ready, a);
        else n_pass++;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic issue_b(input logic wr, input logic [3:0] a, input logic [7:0] d);
        int guard;
        guard = 0;
        req_valid_b = 1'b1; req_wr_b = wr; req_addr_b = a; req_wdata_b = d;
        while (!req_ready_b && guard < 50) begin
            tick();
            guard++;
        end
        n_total++;
        if (req_ready_b !== 1'b1) $display("FAIL issue_ready_b: req_ready=%b required 1 (addr %0d)", req_ready_b, a);
        else n_pass++;
        tick();
        req_valid_b = 1'b0;
    endtask

    // Read on instance a, expect latency of 3 cycles, optional back-pressure, then handshake.
    task automatic read_chk(input logic [3:0] a, input logic [7:0] exp, input int hold, input string name);
        int cyc;
        resp_ready = 1'b0;
        issue(1'b0, a, 8'h00);
        cyc = 1;
        while (!resp_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        n_total++;
        if (resp_valid !== 1'b1 || cyc != 3)
            $display("FAIL %s_latency: valid=%b at cycle %0d required valid=1 at cycle 3", name, resp_valid, cyc);
        else n_pass++;
        n_total++;
        if (resp_rdata !== exp || resp_err !== 1'b0)
            $display("FAIL %s_data: rdata=%h err=%b required rdata=%h err=0", name, resp_rdata, resp_err, exp);
        else n_pass++;
        for (int i = 0; i < hold; i++) begin
            tick();
            n_total++;
            if (resp_valid !== 1'b1 || resp_rdata !== exp || req_ready !== 1'b0)
                $display("FAIL %s_hold%0d: valid=%b rdata=%h req_ready=%b required 1/%h/0",
                         name, i, resp_valid, resp_rdata, req_ready, exp);
            else n_pass++;
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_handshake: valid=%b busy=%b required 0/0", name, resp_valid, busy);
        else n_pass++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; rst_b = 1'b1;
        tick();
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL reset_ready_in_rst: req_ready=%b required 0", req_ready);
        else n_pass++;
        tick();
        rst = 1'b0; rst_b = 1'b0;
        #1;
        n_total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || ram_cs !== 1'b0 || ram_wr !== 1'b0 || ram_oe !== 1'b0)
            $display("FAIL reset_idle: ready=%b busy=%b cs=%b wr=%b oe=%b required 1/0/0/0/0",
                     req_ready, busy, ram_cs, ram_wr, ram_oe);
        else n_pass++;
        n_total++;
        if (resp_valid !== 1'b0 || resp_rdata !== 8'h00 || clr_done !== 1'b0 || resp_err !== 1'b0 || ram_addr !== 4'h0)
            $display("FAIL reset_outputs: valid=%b rdata=%h done=%b err=%b addr=%h required 0/00/0/0/0",
                     resp_valid, resp_rdata, clr_done, resp_err, ram_addr);
        else n_pass++;
    endtask

    task automatic test_write_read();
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_wdata = 8'hA5;
        n_total++;
        if (req_ready !== 1'b1) $display("FAIL wr_ready: req_ready=%b required 1", req_ready);
        else n_pass++;
        tick();
        req_valid = 1'b0;
        n_total++;
        if (ram_cs !== 1'b1 || ram_wr !== 1'b1 || ram_oe !== 1'b0 || ram_addr !== 4'd3 || ram_data !== 8'hA5 || busy !== 1'b1)
            $display("FAIL wr_cycle: cs=%b wr=%b oe=%b addr=%h data=%h busy=%b required 1/1/0/3/a5/1",
                     ram_cs, ram_wr, ram_oe, ram_addr, ram_data, busy);
        else n_pass++;
        tick();
        n_total++;
        if (ram_cs !== 1'b0 || ram_wr !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL wr_done: cs=%b wr=%b busy=%b valid=%b required 0/0/0/0", ram_cs, ram_wr, busy, resp_valid);
        else n_pass++;
        // Walk the read state by state.
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd3;
        tick();
        req_valid = 1'b0;
        n_total++;
        if (ram_cs !== 1'b1 || ram_wr !== 1'b0 || ram_oe !== 1'b0 || ram_addr !== 4'd3)
            $display("FAIL rd_addr_cycle: cs=%b wr=%b oe=%b addr=%h required 1/0/0/3", ram_cs, ram_wr, ram_oe, ram_addr);
        else n_pass++;
        tick();
        n_total++;
        if (ram_cs !== 1'b1 || ram_wr !== 1'b0 || ram_oe !== 1'b1 || resp_valid !== 1'b0)
            $display("FAIL rd_data_cycle: cs=%b wr=%b oe=%b valid=%b required 1/0/1/0", ram_cs, ram_wr, ram_oe, resp_valid);
        else n_pass++;
        tick();
        n_total++;
        if (resp_valid !== 1'b1 || resp_rdata !== 8'hA5 || resp_err !== 1'b0 || ram_cs !== 1'b0 || ram_oe !== 1'b0)
            $display("FAIL rd_resp: valid=%b rdata=%h err=%b cs=%b oe=%b required 1/a5/0/0/0",
                     resp_valid, resp_rdata, resp_err, ram_cs, ram_oe);
        else n_pass++;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_total++;
        if (resp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rd_release: valid=%b busy=%b required 0/0", resp_valid, busy);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        read_chk(4'd3, 8'hA5, 5, "backpressure");
    endtask

    task automatic test_clear();
        int k;
        int guard;
        for (int i = 0; i < 16; i++) issue(1'b1, 4'(i), 8'(i));
        tick();
        read_chk(4'd7, 8'h07, 0, "fill_check");
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        k = 0;
        guard = 0;
        while (!clr_done && guard < 40) begin
            if (ram_cs && ram_wr) begin
                n_total++;
                if (ram_addr !== k[3:0] || ram_data !== 8'h00)
                    $display("FAIL clr_word%0d: addr=%h data=%h required %h/00", k, ram_addr, ram_data, k[3:0]);
                else n_pass++;
                k++;
            end
            // A clr_start mid-clear must be ignored.
            clr_start = (k == 5);
            tick();
            guard++;
        end
        clr_start = 1'b0;
        n_total++;
        if (k != 16 || clr_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL clr_count: words=%0d done=%b busy=%b required 16/1/0", k, clr_done, busy);
        else n_pass++;
        tick();
        n_total++;
        if (clr_done !== 1'b0 || busy !== 1'b0) $display("FAIL clr_pulse: done=%b busy=%b required 0/0", clr_done, busy);
        else n_pass++;
        for (int i = 0; i < 16; i++) read_chk(4'(i), 8'h00, 0, $sformatf("cleared%0d", i));
    endtask

    task automatic test_clr_priority();
        int n;
        clr_start = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 4'd5; req_wdata = 8'h77;
        #1;
        n_total++;
        if (req_ready !== 1'b0) $display("FAIL prio_ready: req_ready=%b required 0", req_ready);
        else n_pass++;
        tick();
        clr_start = 1'b0;
        n_total++;
        if (busy !== 1'b1 || ram_wr !== 1'b1 || ram_addr !== 4'd0 || ram_data !== 8'h00)
            $display("FAIL prio_clear_first: busy=%b wr=%b addr=%h data=%h required 1/1/0/00", busy, ram_wr, ram_addr, ram_data);
        else n_pass++;
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        n_total++;
        if (n != 16 || clr_done !== 1'b1) $display("FAIL prio_wait: cycles=%0d done=%b required 16/1", n, clr_done);
        else n_pass++;
        tick();
        req_valid = 1'b0;
        n_total++;
        if (ram_wr !== 1'b1 || ram_addr !== 4'd5 || ram_data !== 8'h77)
            $display("FAIL prio_served: wr=%b addr=%h data=%h required 1/5/77", ram_wr, ram_addr, ram_data);
        else n_pass++;
        tick();
        read_chk(4'd5, 8'h77, 0, "prio_read5");
        read_chk(4'd6, 8'h00, 0, "prio_read6");
    endtask

    task automatic test_depth12();
        int cyc;
        logic cs_seen;
        logic late_valid;
        // In-range boundary address 11.
        resp_ready_b = 1'b1;
        issue_b(1'b1, 4'd11, 8'h5A);
        tick();
        issue_b(1'b0, 4'd11, 8'h00);
        cyc = 1;
        while (!resp_valid_b && cyc < 10) begin
            tick();
            cyc++;
        end
        n_total++;
        if (resp_valid_b !== 1'b1 || resp_rdata_b !== 8'h5A || resp_err_b !== 1'b0)
            $display("FAIL d12_read11: valid=%b rdata=%h err=%b required 1/5a/0", resp_valid_b, resp_rdata_b, resp_err_b);
        else n_pass++;
        tick();
        resp_ready_b = 1'b0;
        // Write to 12 is dropped.
        issue_b(1'b1, 4'd12, 8'hEE);
        n_total++;
        if (ram_cs_b !== 1'b0 || busy_b !== 1'b0 || req_ready_b !== 1'b1)
            $display("FAIL d12_write12: cs=%b busy=%b ready=%b required 0/0/1", ram_cs_b, busy_b, req_ready_b);
        else n_pass++;
        // Read at 13 answers with an error and never touches the RAM.
        issue_b(1'b0, 4'd13, 8'h00);
        cs_seen = ram_cs_b;
        n_total++;
        if (resp_valid_b !== 1'b1 || resp_err_b !== 1'b1 || resp_rdata_b !== 8'h00)
            $display("FAIL d12_read13: valid=%b err=%b rdata=%h required 1/1/00", resp_valid_b, resp_err_b, resp_rdata_b);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            cs_seen = cs_seen | ram_cs_b;
        end
        resp_ready_b = 1'b1;
        tick();
        cs_seen = cs_seen | ram_cs_b;
        resp_ready_b = 1'b0;
        n_total++;
        if (cs_seen !== 1'b0 || resp_valid_b !== 1'b0 || busy_b !== 1'b0)
            $display("FAIL d12_no_access: cs_seen=%b valid=%b busy=%b required 0/0/0", cs_seen, resp_valid_b, busy_b);
        else n_pass++;
        // Reset during RD_DATA abandons the read.
        issue_b(1'b0, 4'd11, 8'h00);
        tick();
        n_total++;
        if (ram_oe_b !== 1'b1) $display("FAIL d12_in_rd_data: oe=%b required 1", ram_oe_b);
        else n_pass++;
        rst_b = 1'b1;
        tick();
        rst_b = 1'b0;
        #1;
        n_total++;
        if (busy_b !== 1'b0 || resp_valid_b !== 1'b0 || ram_cs_b !== 1'b0 || ram_oe_b !== 1'b0 || resp_rdata_b !== 8'h00)
            $display("FAIL d12_reset: busy=%b valid=%b cs=%b oe=%b rdata=%h required 0/0/0/0/00",
                     busy_b, resp_valid_b, ram_cs_b, ram_oe_b, resp_rdata_b);
        else n_pass++;
        late_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            late_valid = late_valid | resp_valid_b;
        end
        n_total++;
        if (late_valid !== 1'b0 || req_ready_b !== 1'b1)
            $display("FAIL d12_no_resp: late_valid=%b ready=%b required 0/1", late_valid, req_ready_b);
        else n_pass++;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; clr_start = 1'b0;
        rst_b = 1'b1; req_valid_b = 1'b0; req_wr_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
        resp_ready_b = 1'b0; clr_start_b = 1'b0;
        test_reset();
        test_write_read();
        test_back_pressure();
        test_clear();
        test_clr_priority();
        test_depth12();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
